// File: rtl/fifo_pkg.sv
// Shared sizing constants and the round-robin history encoding for the
// two-producer FIFO front end.
package fifo_pkg;
    localparam int DEPTH = 8;
    localparam int WIDTH = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Index of the producer that was granted most recently.
    typedef enum logic {
        LAST_P0 = 1'b0,
        LAST_P1 = 1'b1
    } last_e;
endpackage

// File: rtl/fifo_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the producer
// that was not granted most recently.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    // Grant decode from the request pair and the history bit.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last == 1'b1) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/fifo_arbiter.sv
// Write-side arbiter and pointer/occupancy control for a register-bank FIFO
// fed by two producers and drained by one consumer.
module fifo_arbiter #(
    parameter int  DEPTH = fifo_pkg::DEPTH,
    parameter int  WIDTH = fifo_pkg::WIDTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             pop,
    output logic             gnt0,
    output logic             gnt1,
    output logic             wr_en,
    output logic [AW-1:0]    wr_ptr,
    output logic [WIDTH-1:0] wr_data,
    output logic [AW-1:0]    rd_ptr,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    import fifo_pkg::*;

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    last_e         last_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          full_s;
    logic          empty_s;
    logic [1:0]    req_s;
    logic [1:0]    gnt_s;
    logic          wr_ok_s;
    logic          pop_ok_s;

    // Flags come from the registered count; reset forces the idle view.
    assign full_s  = (reset == 1'b0) && (count_r == CW'(DEPTH));
    assign empty_s = (reset == 1'b1) || (count_r == {CW{1'b0}});

    // A full FIFO or reset masks both requests before arbitration.
    assign req_s = {req1, req0} & {2{~full_s & ~reset}};

    rr_arb2 u_rr_arb2 (
        .req  (req_s),
        .last (last_r),
        .gnt  (gnt_s)
    );

    assign wr_ok_s  = gnt_s[0] | gnt_s[1];
    assign pop_ok_s = pop & ~empty_s & ~reset;

    // Steer the granted producer's word onto the bank write port.
    always_comb begin
        wr_data = {WIDTH{1'b0}};
        if (gnt_s[0] == 1'b1) begin
            wr_data = data0;
        end else if (gnt_s[1] == 1'b1) begin
            wr_data = data1;
        end else begin
            wr_data = {WIDTH{1'b0}};
        end
    end

    // Pointer, occupancy, priority history and sticky error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            last_r      <= LAST_P1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({wr_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
            if (gnt_s[0]) begin
                last_r <= LAST_P0;
            end else if (gnt_s[1]) begin
                last_r <= LAST_P1;
            end
            if (full_s && (req0 || req1)) begin
                overflow_r <= 1'b1;
            end
            if (empty_s && pop) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign gnt0      = gnt_s[0];
    assign gnt1      = gnt_s[1];
    assign wr_en     = wr_ok_s;
    assign wr_ptr    = wr_ptr_r;
    assign rd_ptr    = rd_ptr_r;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;
endmodule
